write_back_multi: RTL
=====================

Name: write_back_multi

Overview:
- Parametrised write-back stage that registers up to LANES results from the memory-access stage.
- Extracts and extends load data (byte/half/word, signed/unsigned) and selects ALU or load data per lane.
- Drives the register-file write ports, resolving same-address conflicts between lanes, and exports a retired-instruction counter.
- Sits between the memory-access stage and the register file; successor of the single-lane write-back stage.

Parameters:
- DATA_W, 32, datapath width; must be 32 for load extraction.
- ADDR_W, 5, register address width.
- LANES, 1, number of parallel write-back lanes (1..4).
- CNT_W, 32, retire counter width.

Ports:
- clk  input  1  clock, rising edge.
- rstn  input  1  asynchronous reset, active-high (asserted = 1) despite the name.
- stall  input  1  freeze stage register; suppress writes and retire count.
- flush  input  1  clear all lane valid bits on next edge.
- in_valid  input  LANES  lane i carries an instruction.
- in_reg_write  input  LANES  lane i writes a register.
- in_mem_to_reg  input  LANES  1 = load data, 0 = ALU result.
- in_load_type  input  3*LANES  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5-7 treated as LW.
- in_mem_addr_lo  input  2*LANES  byte offset of load address.
- in_alu_result  input  DATA_W*LANES  ALU result per lane.
- in_mem_rdata  input  DATA_W*LANES  raw aligned memory word per lane.
- in_write_reg  input  ADDR_W*LANES  destination register per lane.
- reg_write_to_file  output  LANES  register-file write enable per lane.
- reg_write_addr  output  ADDR_W*LANES  write address per lane.
- reg_write_data  output  DATA_W*LANES  write data per lane.
- fwd_valid  output  LANES  lane i holds a valid register-writing result, ungated by stall; for forwarding.
- retire_count  output  CNT_W  instructions retired since reset.

Behaviour:
- Reset (async, rstn=1): all stage registers 0, all valid bits 0, retire_count 0. Consequently all outputs read 0.
- Stage register capture on rising edge:
  - flush=1: valid bits cleared; flush has priority over stall.
  - else stall=0: all lane fields captured from the inputs.
  - else: contents held.
- Latency: one cycle from inputs to register-file write signals.
- Write data computed combinationally from the stage register:
  - mem_to_reg=0 selects alu_result; otherwise load extraction applies.
  - LB/LBU: byte select = addr_lo[1:0], little-endian (byte 0 = bits 7:0); sign- or zero-extend to 32.
  - LH/LHU: half select = addr_lo[1]; addr_lo[0] ignored (no misalign trap here); sign- or zero-extend.
  - LW: full word; addr_lo ignored.
- reg_write_to_file[i] = valid[i] & reg_write[i] & (addr != 0) & !stall, so each instruction writes exactly once.
- Conflict: if lanes i<j both enable the same address in one cycle, lane i's enable is forced 0 (youngest/highest lane wins).
- reg_write_addr and reg_write_data always reflect the stage register, even when the enable is 0.
- fwd_valid[i] = valid[i] & reg_write[i] & (addr != 0); asserted during stall, deasserted after flush.
- retire_count increments each cycle with stall=0 by popcount(valid). Wraps modulo 2^CNT_W with no saturation. flush does not decrement it.
- Reset mid-operation: all state cleared immediately, no partial write.

Test Plan:
1. Reset: rstn=1 while inputs toggle -> all outputs 0. Release, then lane0 valid ALU write r3=0x1234_5678 -> next cycle reg_write_to_file[0]=1, addr 3, data 0x1234_5678; retire_count=1.
2. Load extraction: mem_rdata=0x80FF_7F01 with LB at offsets 0..3 -> 0x0000_0001, 0x0000_007F, 0xFFFF_FFFF, 0xFFFF_FF80. LBU at offset 3 -> 0x80. LH at offset 2 -> 0xFFFF_80FF. LHU at offset 3 -> 0x0000_80FF. Type 6 -> 0x80FF_7F01.
3. Stall: present r5 write, assert stall for 3 cycles -> no enable and retire_count unchanged during stall, fwd_valid[0]=1 held. On stall release the enable pulses once and the count increments by 1.
4. Flush vs stall: stall=1 and flush=1 together with a valid entry -> next cycle fwd_valid=0, no write, count unchanged.
5. LANES=2 conflict: both lanes write r7 (0xAAAA, 0xBBBB) -> only lane1 enabled, data 0xBBBB; count +2. Write to r0 -> no enable, count still +1.
6. Wrap: CNT_W=4, retire 17 instructions -> retire_count=1.

Source files
------------

// File: rtl/write_back_multi.sv
// Multi-lane write-back stage: registers memory-stage results, extracts load data,
// drives register-file write ports with lane conflict resolution and counts retirements.
module write_back_multi #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned LANES  = 1,
   parameter int unsigned CNT_W  = 32
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [LANES-1:0]         in_valid,
   input  logic [LANES-1:0]         in_reg_write,
   input  logic [LANES-1:0]         in_mem_to_reg,
   input  logic [3*LANES-1:0]       in_load_type,
   input  logic [2*LANES-1:0]       in_mem_addr_lo,
   input  logic [DATA_W*LANES-1:0]  in_alu_result,
   input  logic [DATA_W*LANES-1:0]  in_mem_rdata,
   input  logic [ADDR_W*LANES-1:0]  in_write_reg,
   output logic [LANES-1:0]         reg_write_to_file,
   output logic [ADDR_W*LANES-1:0]  reg_write_addr,
   output logic [DATA_W*LANES-1:0]  reg_write_data,
   output logic [LANES-1:0]         fwd_valid,
   output logic [CNT_W-1:0]         retire_count
);

   logic [LANES-1:0]        valid_q,      valid_d;
   logic [LANES-1:0]        reg_write_q,  reg_write_d;
   logic [LANES-1:0]        mem_to_reg_q, mem_to_reg_d;
   logic [3*LANES-1:0]      load_type_q,  load_type_d;
   logic [2*LANES-1:0]      addr_lo_q,    addr_lo_d;
   logic [DATA_W*LANES-1:0] alu_q,        alu_d;
   logic [DATA_W*LANES-1:0] rdata_q,      rdata_d;
   logic [ADDR_W*LANES-1:0] wreg_q,       wreg_d;
   logic [CNT_W-1:0]        cnt_q,        cnt_d;

   logic [CNT_W-1:0]        retire_inc;
   logic [LANES-1:0]        lane_writes;

   // Types 5-7 fall through to the full-word case.
   function automatic logic [DATA_W-1:0] extract_load(input logic [2:0]        load_type,
                                                      input logic [1:0]        addr_lo,
                                                      input logic [DATA_W-1:0] word);
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      byte_v = word[{addr_lo, 3'b000} +: 8];
      half_v = word[{addr_lo[1], 4'b0000} +: 16];
      case (load_type)
         3'd0:    extract_load = {{(DATA_W-8){byte_v[7]}}, byte_v};
         3'd1:    extract_load = {{(DATA_W-8){1'b0}}, byte_v};
         3'd2:    extract_load = {{(DATA_W-16){half_v[15]}}, half_v};
         3'd3:    extract_load = {{(DATA_W-16){1'b0}}, half_v};
         default: extract_load = word;
      endcase
   endfunction

   // Flush beats stall; both beat capture.
   always_comb begin
      valid_d      = valid_q;
      reg_write_d  = reg_write_q;
      mem_to_reg_d = mem_to_reg_q;
      load_type_d  = load_type_q;
      addr_lo_d    = addr_lo_q;
      alu_d        = alu_q;
      rdata_d      = rdata_q;
      wreg_d       = wreg_q;
      if (flush) begin
         valid_d = '0;
      end else if (!stall) begin
         valid_d      = in_valid;
         reg_write_d  = in_reg_write;
         mem_to_reg_d = in_mem_to_reg;
         load_type_d  = in_load_type;
         addr_lo_d    = in_mem_addr_lo;
         alu_d        = in_alu_result;
         rdata_d      = in_mem_rdata;
         wreg_d       = in_write_reg;
      end
   end

   always_comb begin
      retire_inc = '0;
      for (int i = 0; i < LANES; i++) begin
         retire_inc = retire_inc + CNT_W'(valid_q[i]);
      end
      cnt_d = stall ? cnt_q : cnt_q + retire_inc;
   end

   always_ff @(posedge clk or posedge rstn) begin
      if (rstn) begin
         valid_q      <= '0;
         reg_write_q  <= '0;
         mem_to_reg_q <= '0;
         load_type_q  <= '0;
         addr_lo_q    <= '0;
         alu_q        <= '0;
         rdata_q      <= '0;
         wreg_q       <= '0;
         cnt_q        <= '0;
      end else begin
         valid_q      <= valid_d;
         reg_write_q  <= reg_write_d;
         mem_to_reg_q <= mem_to_reg_d;
         load_type_q  <= load_type_d;
         addr_lo_q    <= addr_lo_d;
         alu_q        <= alu_d;
         rdata_q      <= rdata_d;
         wreg_q       <= wreg_d;
         cnt_q        <= cnt_d;
      end
   end

   always_comb begin
      reg_write_data = '0;
      for (int i = 0; i < LANES; i++) begin
         if (mem_to_reg_q[i]) begin
            reg_write_data[i*DATA_W +: DATA_W] =
               extract_load(load_type_q[3*i +: 3], addr_lo_q[2*i +: 2],
                            rdata_q[i*DATA_W +: DATA_W]);
         end else begin
            reg_write_data[i*DATA_W +: DATA_W] = alu_q[i*DATA_W +: DATA_W];
         end
      end
   end

   // A higher lane is younger, so it wins a same-address collision.
   always_comb begin
      lane_writes = '0;
      for (int i = 0; i < LANES; i++) begin
         lane_writes[i] = valid_q[i] & reg_write_q[i] & (wreg_q[i*ADDR_W +: ADDR_W] != '0);
      end
      reg_write_to_file = lane_writes & {LANES{~stall}};
      for (int i = 0; i < LANES; i++) begin
         for (int j = i + 1; j < LANES; j++) begin
            if (lane_writes[j] &&
                (wreg_q[i*ADDR_W +: ADDR_W] == wreg_q[j*ADDR_W +: ADDR_W])) begin
               reg_write_to_file[i] = 1'b0;
            end
         end
      end
   end

   assign fwd_valid      = lane_writes;
   assign reg_write_addr = wreg_q;
   assign retire_count   = cnt_q;

endmodule
